// File: rtl/axi_lite_regfile_if.sv
// AXI-Lite response codes and the five-channel axi_lite_channel bundle
// shared by the control-path endpoints.
package axi_lite_pkg;
    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;
endpackage

interface axi_lite_channel #(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64
);
    import axi_lite_pkg::*;

    logic                    clk;
    logic                    rstn;

    logic                    aw_valid;
    logic                    aw_ready;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [2:0]              aw_prot;

    logic                    w_valid;
    logic                    w_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;

    logic                    b_valid;
    logic                    b_ready;
    resp_t                   b_resp;

    logic                    ar_valid;
    logic                    ar_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [2:0]              ar_prot;

    logic                    r_valid;
    logic                    r_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    resp_t                   r_resp;

    modport slave (
        input  clk, rstn,
        input  aw_valid, aw_addr, aw_prot, output aw_ready,
        input  w_valid, w_data, w_strb,    output w_ready,
        output b_valid, b_resp,            input  b_ready,
        input  ar_valid, ar_addr, ar_prot, output ar_ready,
        output r_valid, r_data, r_resp,    input  r_ready
    );

    modport master (
        input  clk, rstn,
        output aw_valid, aw_addr, aw_prot, input  aw_ready,
        output w_valid, w_data, w_strb,    input  w_ready,
        input  b_valid, b_resp,            output b_ready,
        output ar_valid, ar_addr, ar_prot, input  ar_ready,
        input  r_valid, r_data, r_resp,    output r_ready
    );
endinterface

// File: rtl/axi_lite_regfile.sv
// AXI-Lite register bank: byte-strobed writes, DECERR outside NUM_REGS,
// flat register export with a one-cycle write pulse per register.
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int                    NUM_REGS    = 16,
    parameter int                    ADDR_WIDTH  = 48,
    parameter int                    DATA_WIDTH  = 64,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    axi_lite_channel.slave                 master,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int OFS        = $clog2(STRB_WIDTH);
    localparam int IW         = ADDR_WIDTH - OFS;

    if (NUM_REGS < 1) begin : g_bad_num_regs
        $fatal(1, "axi_lite_regfile: NUM_REGS must be >= 1");
    end
    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
        $fatal(1, "axi_lite_regfile: DATA_WIDTH must be 32 or 64");
    end
    if ($bits(master.aw_addr) != ADDR_WIDTH) begin : g_addr_mismatch
        $fatal(1, "axi_lite_regfile: ADDR_WIDTH differs from interface");
    end
    if ($bits(master.w_data) != DATA_WIDTH) begin : g_data_mismatch
        $fatal(1, "axi_lite_regfile: DATA_WIDTH differs from interface");
    end

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];

    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;

    logic                  b_valid_q, r_valid_q;
    resp_t                 b_resp_q, r_resp_q;
    logic [DATA_WIDTH-1:0] r_data_q;

    logic                  aw_ready, w_ready, ar_ready;
    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [IW-1:0]         wr_idx, rd_idx;
    logic                  wr_hit, rd_hit;
    logic [DATA_WIDTH-1:0] rd_word;

    assign aw_ready = !aw_held && !rst;
    assign w_ready  = !w_held && !rst;
    assign ar_ready = (!r_valid_q || master.r_ready) && !rst;

    assign aw_hs  = master.aw_valid && aw_ready;
    assign w_hs   = master.w_valid && w_ready;
    assign ar_hs  = master.ar_valid && ar_ready;
    assign commit = aw_held && w_held && (!b_valid_q || master.b_ready);

    assign master.aw_ready = aw_ready;
    assign master.w_ready  = w_ready;
    assign master.ar_ready = ar_ready;
    assign master.b_valid  = b_valid_q;
    assign master.b_resp   = b_resp_q;
    assign master.r_valid  = r_valid_q;
    assign master.r_data   = r_data_q;
    assign master.r_resp   = r_resp_q;

    // Protection bits, byte-offset bits and the bundle's own clock/reset are not used.
    logic unused_ok;
    assign unused_ok = ^{master.clk, master.rstn, master.aw_prot, master.ar_prot,
                         aw_addr_q[OFS-1:0], master.ar_addr[OFS-1:0]};

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        wr_idx  = aw_addr_q[ADDR_WIDTH-1:OFS];
        rd_idx  = master.ar_addr[ADDR_WIDTH-1:OFS];
        wr_hit  = wr_idx < IW'(NUM_REGS);
        rd_hit  = rd_idx < IW'(NUM_REGS);
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IW'(i)) rd_word = mem[i];
        end
    end

    always_comb begin
        regs = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs[i*DATA_WIDTH +: DATA_WIDTH] = mem[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so the AR read below
    // sees the pre-commit register value on a same-edge collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_valid_q <= 1'b0;
            b_resp_q  <= RESP_OKAY;
            r_valid_q <= 1'b0;
            r_resp_q  <= RESP_OKAY;
            r_data_q  <= '0;
            wr_pulse  <= '0;
            // NOTE: the bank is flops, not RAM, so it is reset as a whole to RESET_VALUE.
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= RESET_VALUE;
            end
        end else begin
            wr_pulse <= '0;

            if (aw_hs) begin
                aw_addr_q <= master.aw_addr;
                aw_held   <= 1'b1;
            end
            if (w_hs) begin
                w_data_q <= master.w_data;
                w_strb_q <= master.w_strb;
                w_held   <= 1'b1;
            end

            if (commit) begin
                aw_held   <= 1'b0;
                w_held    <= 1'b0;
                b_valid_q <= 1'b1;
                b_resp_q  <= wr_hit ? RESP_OKAY : RESP_DECERR;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (wr_hit && wr_idx == IW'(i)) begin
                        wr_pulse[i] <= 1'b1;
                        for (int k = 0; k < STRB_WIDTH; k++) begin
                            if (w_strb_q[k]) mem[i][8*k +: 8] <= w_data_q[8*k +: 8];
                        end
                    end
                end
            end else if (b_valid_q && master.b_ready) begin
                b_valid_q <= 1'b0;
            end

            if (ar_hs) begin
                r_valid_q <= 1'b1;
                r_data_q  <= rd_word;
                r_resp_q  <= rd_hit ? RESP_OKAY : RESP_DECERR;
            end else if (r_valid_q && master.r_ready) begin
                r_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Self-checking bench for axi_lite_regfile: vector table for single accesses,
// hand sequences for ordering, backpressure, collision and reset corners.
module tb_axi_lite_regfile;
    import axi_lite_pkg::*;

    localparam int NR = 16;
    localparam int AW = 48;
    localparam int DW = 64;
    localparam logic [DW-1:0] RV = 64'hCAFE_0000_1234_5678;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR*DW-1:0] regs;
    logic [NR-1:0] wr_pulse;

    axi_lite_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    assign bus.clk  = clk;
    assign bus.rstn = !rst;

    axi_lite_regfile #(
        .NUM_REGS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_VALUE(RV)
    ) dut (
        .clk(clk), .rst(rst), .master(bus), .regs(regs), .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } rexp_t;

    logic [1:0] b_q[$];
    rexp_t      r_q[$];
    logic [DW-1:0] model [NR];

    typedef struct {
        bit            is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [7:0]    strb;
        int            idx;
        logic [DW-1:0] exp;
        logic [1:0]    resp;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++)
            check($sformatf("%s regs[%0d]", tag, i), regs[i*DW +: DW], model[i]);
    endtask

    // Scoreboard: pop expected responses as each B/R handshake is about to happen.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.b_valid && bus.b_ready) begin
                if (b_q.size() == 0) check("b_unexpected", 64'd1, 64'd0);
                else check("b_resp", 64'(bus.b_resp), 64'(b_q.pop_front()));
            end
            if (bus.r_valid && bus.r_ready) begin
                if (r_q.size() == 0) check("r_unexpected", 64'd1, 64'd0);
                else begin
                    rexp_t e;
                    e = r_q.pop_front();
                    check("r_data", bus.r_data, e.data);
                    check("r_resp", 64'(bus.r_resp), 64'(e.resp));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_aw_w(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [7:0] strb);
        bit a_done = 0, w_done = 0, a_rdy, w_rdy;
        int t = 0;
        bus.aw_addr = addr; bus.w_data = data; bus.w_strb = strb;
        bus.aw_valid = 1'b1; bus.w_valid = 1'b1;
        while (!(a_done && w_done) && t < 40) begin
            @(negedge clk);
            a_rdy = bus.aw_ready; w_rdy = bus.w_ready;
            @(posedge clk); #1;
            if (a_rdy && !a_done) begin a_done = 1; bus.aw_valid = 1'b0; end
            if (w_rdy && !w_done) begin w_done = 1; bus.w_valid = 1'b0; end
            t++;
        end
        if (!(a_done && w_done)) check("aw_w_handshake_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_ar(input logic [AW-1:0] addr);
        bit done = 0, rdy;
        int t = 0;
        bus.ar_addr = addr; bus.ar_valid = 1'b1;
        while (!done && t < 40) begin
            @(negedge clk);
            rdy = bus.ar_ready;
            @(posedge clk); #1;
            if (rdy) begin done = 1; bus.ar_valid = 1'b0; end
            t++;
        end
        if (!done) check("ar_handshake_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((b_q.size() != 0 || r_q.size() != 0) && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_b_queue", 64'(b_q.size()), 64'd0);
        check("drain_r_queue", 64'(r_q.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.aw_valid = 0; bus.aw_addr = '0; bus.aw_prot = '0;
        bus.w_valid = 0;  bus.w_data = '0;  bus.w_strb = '0;
        bus.ar_valid = 0; bus.ar_addr = '0; bus.ar_prot = '0;
        bus.b_ready = 1'b1; bus.r_ready = 1'b1;
        for (int i = 0; i < NR; i++) model[i] = RV;

        vecs[0]  = '{0, 48'h08, '0, 8'h00, 1, RV, 2'b00};
        vecs[1]  = '{1, 48'h08, 64'h0, 8'hFF, 1, 64'h0, 2'b00};
        vecs[2]  = '{1, 48'h08, 64'h1122334455667788, 8'h0F, 1, 64'h0000000055667788, 2'b00};
        vecs[3]  = '{0, 48'h08, '0, 8'h00, 1, 64'h0000000055667788, 2'b00};
        vecs[4]  = '{1, 48'h13, 64'h0123456789ABCDEF, 8'hF0, 2, 64'h0123456712345678, 2'b00};
        vecs[5]  = '{0, 48'h10, '0, 8'h00, 2, 64'h0123456712345678, 2'b00};
        vecs[6]  = '{1, 48'h80, 64'hFFFFFFFFFFFFFFFF, 8'hFF, -1, '0, 2'b11};
        vecs[7]  = '{0, 48'h84, '0, 8'h00, -1, 64'h0, 2'b11};
        vecs[8]  = '{1, 48'h7F, 64'h1, 8'h00, 15, RV, 2'b00};
        vecs[9]  = '{0, 48'h78, '0, 8'h00, 15, RV, 2'b00};
        vecs[10] = '{0, 48'hFFFF_0000_0008, '0, 8'h00, -1, 64'h0, 2'b11};
        vecs[11] = '{1, 48'h78, 64'h8877665544332211, 8'h81, 15, 64'h88FE000012345611, 2'b00};
        vecs[12] = '{0, 48'h78, '0, 8'h00, 15, 64'h88FE000012345611, 2'b00};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("aw_ready_in_reset", 64'(bus.aw_ready), 64'd0);
        check("w_ready_in_reset", 64'(bus.w_ready), 64'd0);
        check("ar_ready_in_reset", 64'(bus.ar_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("aw_ready_after_reset", 64'(bus.aw_ready), 64'd1);
        check("w_ready_after_reset", 64'(bus.w_ready), 64'd1);
        check("ar_ready_after_reset", 64'(bus.ar_ready), 64'd1);
        check("b_valid_after_reset", 64'(bus.b_valid), 64'd0);
        check("r_valid_after_reset", 64'(bus.r_valid), 64'd0);
        check("r_data_after_reset", bus.r_data, 64'd0);
        check("wr_pulse_after_reset", 64'(wr_pulse), 64'd0);
        check_regs("reset");

        // Single-access vectors
        for (int v = 0; v < 13; v++) begin
            if (vecs[v].is_wr) begin
                b_q.push_back(vecs[v].resp);
                send_aw_w(vecs[v].addr, vecs[v].data, vecs[v].strb);
                check($sformatf("v%0d b_valid_before_commit", v), 64'(bus.b_valid), 64'd0);
                @(posedge clk); #1;
                check($sformatf("v%0d b_valid_at_commit", v), 64'(bus.b_valid), 64'd1);
                if (vecs[v].idx >= 0) begin
                    check($sformatf("v%0d wr_pulse", v), 64'(wr_pulse), 64'(1) << vecs[v].idx);
                    model[vecs[v].idx] = vecs[v].exp;
                end else begin
                    check($sformatf("v%0d wr_pulse", v), 64'(wr_pulse), 64'd0);
                end
                check_regs($sformatf("v%0d", v));
                @(posedge clk); #1;
                check($sformatf("v%0d wr_pulse_cleared", v), 64'(wr_pulse), 64'd0);
            end else begin
                r_q.push_back('{data: vecs[v].exp, resp: vecs[v].resp});
                send_ar(vecs[v].addr);
                check($sformatf("v%0d r_valid", v), 64'(bus.r_valid), 64'd1);
                @(posedge clk); #1;
            end
        end
        wait_drain();

        // W three cycles ahead of AW, to register 2
        b_q.push_back(2'b00);
        @(negedge clk);
        check("reord w_ready_idle", 64'(bus.w_ready), 64'd1);
        @(posedge clk); #1;
        bus.w_data = 64'hA5A5A5A5A5A5A5A5; bus.w_strb = 8'hFF; bus.w_valid = 1'b1;
        @(posedge clk); #1;
        bus.w_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("reord w_ready_held", 64'(bus.w_ready), 64'd0);
            check("reord b_valid_idle", 64'(bus.b_valid), 64'd0);
            @(posedge clk); #1;
        end
        bus.aw_addr = 48'h10; bus.aw_valid = 1'b1;
        @(negedge clk);
        check("reord aw_ready", 64'(bus.aw_ready), 64'd1);
        check("reord w_ready_still_held", 64'(bus.w_ready), 64'd0);
        @(posedge clk); #1;
        bus.aw_valid = 1'b0;
        check("reord b_valid_pre", 64'(bus.b_valid), 64'd0);
        @(posedge clk); #1;
        model[2] = 64'hA5A5A5A5A5A5A5A5;
        check("reord b_valid", 64'(bus.b_valid), 64'd1);
        check("reord wr_pulse", 64'(wr_pulse), 64'h4);
        check("reord reg2", regs[2*DW +: DW], model[2]);
        wait_drain();

        // Backpressure: DECERR write then reg5 write; reads of reg0 and reg1
        bus.b_ready = 1'b0; bus.r_ready = 1'b0;
        b_q.push_back(2'b11);
        b_q.push_back(2'b00);
        r_q.push_back('{data: model[0], resp: 2'b00});
        r_q.push_back('{data: model[1], resp: 2'b00});
        fork
            send_aw_w(48'h80, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF);
            send_ar(48'h00);
        join
        fork
            send_aw_w(48'h28, 64'h5555_AAAA_0000_FFFF, 8'hFF);
            send_ar(48'h08);
        join_none
        @(posedge clk); #1;
        repeat (5) begin
            @(negedge clk);
            check("bp b_valid", 64'(bus.b_valid), 64'd1);
            check("bp b_resp_stable", 64'(bus.b_resp), 64'(RESP_DECERR));
            check("bp r_valid", 64'(bus.r_valid), 64'd1);
            check("bp r_data_stable", bus.r_data, RV);
            check("bp ar_ready", 64'(bus.ar_ready), 64'd0);
            check("bp reg5_uncommitted", regs[5*DW +: DW], RV);
            check("bp wr_pulse", 64'(wr_pulse), 64'd0);
        end
        @(posedge clk); #1;
        bus.b_ready = 1'b1;
        @(posedge clk); #1;
        model[5] = 64'h5555_AAAA_0000_FFFF;
        check("bp drain b_valid", 64'(bus.b_valid), 64'd1);
        check("bp drain b_resp", 64'(bus.b_resp), 64'(RESP_OKAY));
        check("bp drain wr_pulse", 64'(wr_pulse), 64'h20);
        check("bp drain reg5", regs[5*DW +: DW], model[5]);
        bus.r_ready = 1'b1;
        @(posedge clk); #1;
        check("bp b_valid_cleared", 64'(bus.b_valid), 64'd0);
        check("bp second r_valid", 64'(bus.r_valid), 64'd1);
        check("bp second r_data", bus.r_data, model[1]);
        wait_drain();
        check_regs("bp");

        // Same-edge AR and commit to register 3 return the old value
        b_q.push_back(2'b00);
        r_q.push_back('{data: model[3], resp: 2'b00});
        bus.aw_addr = 48'h18; bus.w_data = 64'h3333_3333_C0DE_0003; bus.w_strb = 8'hFF;
        bus.aw_valid = 1'b1; bus.w_valid = 1'b1;
        @(negedge clk);
        check("coll aw_ready", 64'(bus.aw_ready), 64'd1);
        @(posedge clk); #1;
        bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
        bus.ar_addr = 48'h18; bus.ar_valid = 1'b1;
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
        model[3] = 64'h3333_3333_C0DE_0003;
        check("coll r_data_old", bus.r_data, RV);
        check("coll reg3_new", regs[3*DW +: DW], model[3]);
        wait_drain();

        // Reset with a held AW: never produces a B
        bus.aw_addr = 48'h18; bus.aw_valid = 1'b1;
        @(posedge clk); #1;
        bus.aw_valid = 1'b0;
        check("rst aw_held", 64'(bus.aw_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = RV;
        #1;
        check("rst aw_ready_released", 64'(bus.aw_ready), 64'd1);
        bus.w_data = 64'h1; bus.w_strb = 8'hFF; bus.w_valid = 1'b1;
        @(posedge clk); #1;
        bus.w_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rst no_b", 64'(bus.b_valid), 64'd0);
        end
        check_regs("rst");

        check("final b_queue", 64'(b_q.size()), 64'd0);
        check("final r_queue", 64'(r_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
